// File: rtl/reprodutor_jogadas_pkg.sv
// Shared definitions for the move replayer: FSM state encoding and the
// default display timing (cycles lit / cycles blank per move).
package reprodutor_jogadas_pkg;

    localparam int DEF_N    = 6;
    localparam int DEF_M    = 32;
    localparam int DEF_TON  = 50000000;
    localparam int DEF_TOFF = 25000000;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ACENDE = 2'b01,
        APAGA  = 2'b10,
        FIM    = 2'b11
    } estado_t;

endpackage

// File: rtl/reprodutor_jogadas_if.sv
// Handshake bundle between the replay controller and its user: start
// request and move count in, memory address and display status out.
interface reprodutor_jogadas_if
    import reprodutor_jogadas_pkg::*;
#(
    parameter int N = DEF_N
);

    logic         iniciar;
    logic [N-1:0] limite;
    logic [N-1:0] endereco;
    logic         mostra;
    logic         ocupado;
    logic         pronto;

    modport master (
        output iniciar,
        output limite,
        input  endereco,
        input  mostra,
        input  ocupado,
        input  pronto
    );

    modport slave (
        input  iniciar,
        input  limite,
        output endereco,
        output mostra,
        output ocupado,
        output pronto
    );

endinterface

// File: rtl/reprodutor_jogadas_temporizador.sv
// Phase timer: counts enabled cycles from zero and flags the last cycle of
// a T-cycle window. Saturates at T-1 so it can never wrap.
module temporizador
    import reprodutor_jogadas_pkg::*;
#(
    parameter int T = 1
) (
    input  logic clock,
    input  logic rst_n,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (T > 1) ? $clog2(T) : 1;
    localparam logic [W-1:0] ULTIMO = W'(T - 1);

    logic [W-1:0] valor_q;
    logic [W-1:0] valor_d;

    // Next count: clear has priority, otherwise advance until the last cycle.
    always_comb begin
        valor_d = valor_q;
        if (zera) begin
            valor_d = '0;
        end else if (conta && (valor_q != ULTIMO)) begin
            valor_d = valor_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign fim = (valor_q == ULTIMO);

endmodule

// File: rtl/reprodutor_jogadas.sv
// Move replayer: on a start request, steps the sequence memory address from
// 0 up to the latched move count, lighting each move for TON cycles and
// blanking for TOFF cycles, then pulses pronto once.
module reprodutor_jogadas
    import reprodutor_jogadas_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int M    = DEF_M,
    parameter int TON  = DEF_TON,
    parameter int TOFF = DEF_TOFF
) (
    input  logic                  clock,
    input  logic                  rst_n,
    reprodutor_jogadas_if.slave   bus
);

    localparam logic [N-1:0] M_N = N'(M);

    estado_t      estado_q;
    estado_t      estado_d;
    logic [N-1:0] endereco_q;
    logic [N-1:0] endereco_d;
    logic [N-1:0] limite_reg_q;
    logic [N-1:0] limite_reg_d;

    logic         fim_acende;
    logic         fim_apaga;
    logic         zera_acende;
    logic         zera_apaga;
    logic         conta_acende;
    logic         conta_apaga;

    // Each phase has its own timer sized to its own length; a timer is held
    // at zero outside its phase and on its final cycle, so every phase
    // entry starts from a cleared count.
    assign conta_acende = (estado_q == ACENDE);
    assign conta_apaga  = (estado_q == APAGA);
    assign zera_acende  = !conta_acende || fim_acende;
    assign zera_apaga   = !conta_apaga  || fim_apaga;

    temporizador #(.T(TON)) u_tempo_acende (
        .clock (clock),
        .rst_n (rst_n),
        .zera  (zera_acende),
        .conta (conta_acende),
        .fim   (fim_acende)
    );

    temporizador #(.T(TOFF)) u_tempo_apaga (
        .clock (clock),
        .rst_n (rst_n),
        .zera  (zera_apaga),
        .conta (conta_apaga),
        .fim   (fim_apaga)
    );

    // Next-state, address and latched-limit logic for the replay sequence.
    always_comb begin
        estado_d     = estado_q;
        endereco_d   = endereco_q;
        limite_reg_d = limite_reg_q;
        unique case (estado_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    limite_reg_d = (bus.limite > M_N) ? M_N : bus.limite;
                    endereco_d   = '0;
                    estado_d     = ACENDE;
                end
            end
            ACENDE: begin
                if (fim_acende) begin
                    estado_d = APAGA;
                end
            end
            APAGA: begin
                if (fim_apaga) begin
                    if (endereco_q == limite_reg_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + N'(1);
                        estado_d   = ACENDE;
                    end
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State, address and latched-limit registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            endereco_q   <= '0;
            limite_reg_q <= '0;
        end else begin
            estado_q     <= estado_d;
            endereco_q   <= endereco_d;
            limite_reg_q <= limite_reg_d;
        end
    end

    assign bus.endereco = endereco_q;
    assign bus.mostra   = (estado_q == ACENDE);
    assign bus.ocupado  = (estado_q != OCIOSO);
    assign bus.pronto   = (estado_q == FIM);

endmodule

// File: tb/tb_reprodutor_jogadas.sv
// Self-checking bench for reprodutor_jogadas with short timing (TON=4,
// TOFF=2, M=32). Expected addresses and completions go into a scoreboard
// when a replay is started and are popped when the DUT shows a move or
// pulses pronto.
module tb_reprodutor_jogadas;
    import reprodutor_jogadas_pkg::*;

    localparam int N    = 6;
    localparam int M    = 32;
    localparam int TON  = 4;
    localparam int TOFF = 2;

    typedef struct {
        bit is_pronto;
        int addr;
    } exp_t;

    logic clock = 1'b0;
    logic rst_n = 1'b1;

    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    reprodutor_jogadas_if #(.N(N)) bus ();

    reprodutor_jogadas #(
        .N    (N),
        .M    (M),
        .TON  (TON),
        .TOFF (TOFF)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic popCheck(input bit is_pronto, input string tag);
        exp_t e;
        n_compared++;
        assert (sb.size() != 0) else begin
            n_mismatched++;
            $error("[TB] FAIL %s_unexpected: observed %0d queued entries expected at least 1", tag, sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_kind"}, 32'(is_pronto), 32'(e.is_pronto));
            checkOutput(tag, 32'(bus.endereco), e.addr);
        end
    endtask

    // Queue the expected replay and present the start request for one edge.
    task automatic applyStimulus(input int lim);
        int last;
        last = (lim > M) ? M : lim;
        for (int a = 0; a <= last; a++) sb.push_back('{1'b0, a});
        sb.push_back('{1'b1, last});
        bus.limite  = N'(lim);
        bus.iniciar = 1'b1;
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
    endtask

    // Count cycles from the start edge until pronto, optionally disturbing
    // iniciar and limite while the replay runs.
    task automatic waitPronto(input string tag, input int exp_cycle, input bit disturb);
        int got;
        got = -1;
        for (int cyc = 1; cyc <= exp_cycle + 20; cyc++) begin
            @(negedge clock);
            if (cyc == 1) checkOutput({tag, "_mostra_c1"}, 32'(bus.mostra), 1);
            if (bus.pronto) begin
                got = cyc;
                break;
            end
            if (disturb) begin
                bus.limite  = N'(9);
                bus.iniciar = (cyc % 3 == 0);
            end
        end
        bus.iniciar = 1'b0;
        checkOutput({tag, "_pronto_cycle"}, got, exp_cycle);
    endtask

    // Monitor: pops the scoreboard on each shown move and each pronto, and
    // checks lit width and blank gap between consecutive moves.
    initial begin
        int  hi_cnt;
        int  lo_cnt;
        logic mostra_prev;
        hi_cnt      = 0;
        lo_cnt      = 0;
        mostra_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                hi_cnt      = 0;
                lo_cnt      = 0;
                mostra_prev = 1'b0;
            end else begin
                if (bus.mostra && !mostra_prev) begin
                    if (lo_cnt > 0) checkOutput("gap_toff", lo_cnt, TOFF);
                    lo_cnt = 0;
                    popCheck(1'b0, "move_endereco");
                end
                if (!bus.mostra && mostra_prev) checkOutput("width_ton", hi_cnt, TON);
                if (bus.mostra) hi_cnt++;
                else hi_cnt = 0;
                if (!bus.mostra && bus.ocupado) lo_cnt++;
                if (!bus.ocupado) lo_cnt = 0;
                if (bus.pronto) popCheck(1'b1, "pronto_endereco");
                mostra_prev = bus.mostra;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no completion expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        bus.iniciar = 1'b0;
        bus.limite  = '0;

        // Reset values, asserted asynchronously before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_endereco", 32'(bus.endereco), 0);
        checkOutput("rst_mostra",   32'(bus.mostra),   0);
        checkOutput("rst_ocupado",  32'(bus.ocupado),  0);
        checkOutput("rst_pronto",   32'(bus.pronto),   0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // Single move.
        #1;
        applyStimulus(0);
        waitPronto("lim0", 7, 1'b0);
        @(negedge clock);
        checkOutput("lim0_ocupado_c8", 32'(bus.ocupado), 0);
        checkOutput("lim0_endereco",   32'(bus.endereco), 0);

        // Four moves, address holds afterwards.
        @(negedge clock);
        #1;
        applyStimulus(3);
        waitPronto("lim3", 25, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("lim3_endereco_hold", 32'(bus.endereco), 3);
        checkOutput("lim3_ocupado",       32'(bus.ocupado),  0);

        // Inputs disturbed during the replay must not matter.
        @(negedge clock);
        #1;
        applyStimulus(2);
        waitPronto("lim2_disturb", 19, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("lim2_endereco_end", 32'(bus.endereco), 2);
        checkOutput("lim2_ocupado",      32'(bus.ocupado),  0);

        // Limit above M clamps.
        @(negedge clock);
        #1;
        applyStimulus(40);
        waitPronto("lim40", 199, 1'b0);
        @(negedge clock);
        checkOutput("lim40_endereco", 32'(bus.endereco), 32);

        // Reset during the second lit cycle of move 1.
        @(negedge clock);
        #1;
        applyStimulus(3);
        repeat (8) @(negedge clock);
        checkOutput("abort_pre_mostra",   32'(bus.mostra),   1);
        checkOutput("abort_pre_endereco", 32'(bus.endereco), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mostra",   32'(bus.mostra),   0);
        checkOutput("abort_ocupado",  32'(bus.ocupado),  0);
        checkOutput("abort_endereco", 32'(bus.endereco), 0);
        checkOutput("abort_pronto",   32'(bus.pronto),   0);
        sb.delete();
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        #1;
        applyStimulus(2);
        waitPronto("after_reset", 19, 1'b0);

        // iniciar in the FIM cycle is ignored, the following cycle starts.
        @(negedge clock);
        #1;
        applyStimulus(0);
        waitPronto("fim_first", 7, 1'b0);
        bus.limite  = N'(1);
        bus.iniciar = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("fim_ignored_ocupado", 32'(bus.ocupado), 0);
        applyStimulus(1);
        waitPronto("fim_second", 13, 1'b0);

        repeat (3) @(negedge clock);
        checkOutput("final_ocupado", 32'(bus.ocupado), 0);
        checkOutput("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
